// File: rtl/seq_multiplier_responder.sv
// ============================================================================
// Module   : seq_multiplier_responder
// Brief    : Digit-serial unsigned multiplier behind an enable/done handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_multiplier_responder #(
    parameter int WIDTH       = 128,
    parameter int DIGIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 enable,
    output logic [2*WIDTH-1:0]   ab,
    output logic                 done,
    output logic                 busy
);

    localparam int c_NUM_DIGITS = WIDTH / DIGIT_WIDTH;
    localparam int c_ACC_W      = 2 * WIDTH;
    localparam int c_PP_W       = WIDTH + DIGIT_WIDTH;
    localparam int c_CNT_W      = (c_NUM_DIGITS > 1) ? $clog2(c_NUM_DIGITS) : 1;
    localparam int c_SH_W       = $clog2(c_ACC_W) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [WIDTH-1:0]     r_a_q, w_a_d;
    logic [WIDTH-1:0]     r_b_q, w_b_d;
    logic [c_ACC_W-1:0]   r_acc_q, w_acc_d;
    logic [c_ACC_W-1:0]   r_ab_q, w_ab_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic                 r_done_q, w_done_d;
    logic                 r_busy_q, w_busy_d;

    logic [c_PP_W-1:0]    w_pp;
    logic [c_SH_W-1:0]    w_shamt;
    logic [c_ACC_W-1:0]   w_sum;

    // Low digit of the shifting multiplier times the full multiplicand,
    // aligned to the digit position reached so far.
    assign w_pp    = {{DIGIT_WIDTH{1'b0}}, r_a_q} * {{WIDTH{1'b0}}, r_b_q[DIGIT_WIDTH-1:0]};
    assign w_shamt = c_SH_W'(r_cnt_q) * c_SH_W'(DIGIT_WIDTH);
    assign w_sum   = r_acc_q + (c_ACC_W'(w_pp) << w_shamt);

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_acc_d   = r_acc_q;
        w_ab_d    = r_ab_q;
        w_cnt_d   = r_cnt_q;
        w_done_d  = r_done_q;
        w_busy_d  = r_busy_q;

        case (r_state_q)
            ST_IDLE: begin
                if (enable) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
                    w_busy_d  = 1'b1;
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A dropped request wins even on the final digit.
                if (!enable) begin
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
                    w_busy_d  = 1'b0;
                    w_state_d = ST_IDLE;
                end else begin
                    w_acc_d = w_sum;
                    w_b_d   = r_b_q >> DIGIT_WIDTH;
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                    if (r_cnt_q == c_LAST_CNT) begin
                        w_ab_d    = w_sum;
                        w_cnt_d   = '0;
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                        w_state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    w_done_d  = 1'b0;
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= ST_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_acc_q   <= '0;
            r_ab_q    <= '0;
            r_cnt_q   <= '0;
            r_done_q  <= 1'b0;
            r_busy_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_acc_q   <= w_acc_d;
            r_ab_q    <= w_ab_d;
            r_cnt_q   <= w_cnt_d;
            r_done_q  <= w_done_d;
            r_busy_q  <= w_busy_d;
        end
    end

    assign ab   = r_ab_q;
    assign done = r_done_q;
    assign busy = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier_responder.sv
// ============================================================================
// Module   : tb_seq_multiplier_responder
// Brief    : Randomized scoreboard bench for three digit widths of the multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_multiplier_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] a;
    logic [127:0] b;
    logic         enable;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] rnd128();
        logic [127:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: v = v & 128'hFFFF;
            1: v = ~v & {$urandom(), 96'h0};
            2: v = '1;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [255:0] prod(input logic [127:0] x, input logic [127:0] y);
        logic [255:0] xe;
        logic [255:0] ye;
        xe = {128'd0, x};
        ye = {128'd0, y};
        return xe * ye;
    endfunction

    task automatic chk(input string name, input int dw, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [dw=%0d] cyc=%0d: got %h, expected %h", name, dw, cyc, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int DW = (gi == 0) ? 16 : ((gi == 1) ? 32 : 128);
        localparam int NN = 128 / DW;

        logic [255:0] ab_w;
        logic         done_w;
        logic         busy_w;

        seq_multiplier_responder #(
            .WIDTH      (128),
            .DIGIT_WIDTH(DW)
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .a     (a),
            .b     (b),
            .enable(enable),
            .ab    (ab_w),
            .done  (done_w),
            .busy  (busy_w)
        );

        // Reference: a request captured at an idle edge completes NN edges later
        // unless the request is withdrawn or reset intervenes.
        logic [255:0] q_ab[$];
        int           q_due[$];
        int           phase   = 0;
        int           left    = 0;
        bit           pend    = 0;
        logic [255:0] m_pend  = '0;
        logic [255:0] m_ab    = '0;
        logic         m_done  = 1'b0;
        logic         m_busy  = 1'b0;

        initial begin
            forever begin
                @(posedge clk);
                if (!rst) begin
                    if (pend && q_ab.size() > 0) begin
                        void'(q_ab.pop_back());
                        void'(q_due.pop_back());
                    end
                    pend = 0; phase = 0; m_ab = '0; m_done = 1'b0; m_busy = 1'b0;
                end else if (phase == 0) begin
                    if (enable) begin
                        m_pend = prod(a, b);
                        q_ab.push_back(m_pend);
                        q_due.push_back(cyc + NN + 1);
                        pend = 1; phase = 1; left = NN; m_busy = 1'b1;
                    end
                end else if (phase == 1) begin
                    if (!enable) begin
                        if (pend && q_ab.size() > 0) begin
                            void'(q_ab.pop_back());
                            void'(q_due.pop_back());
                        end
                        pend = 0; phase = 0; m_busy = 1'b0;
                    end else begin
                        left--;
                        if (left == 0) begin
                            phase = 2; pend = 0; m_busy = 1'b0; m_done = 1'b1; m_ab = m_pend;
                        end
                    end
                end else if (!enable) begin
                    phase = 0; m_done = 1'b0;
                end
            end
        end

        initial begin
            logic         prev_done;
            logic [255:0] exp_ab;
            int           exp_due;
            prev_done = 1'b0;
            forever begin
                @(negedge clk);
                chk("busy", DW, 256'(busy_w), 256'(m_busy));
                chk("done", DW, 256'(done_w), 256'(m_done));
                chk("ab_hold", DW, ab_w, m_ab);
                chk("busy_done_excl", DW, 256'(busy_w & done_w), 256'd0);
                if (done_w === 1'b1 && prev_done !== 1'b1) begin
                    if (q_ab.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done [dw=%0d] cyc=%0d: got done=1, expected no pending op",
                                 DW, cyc);
                    end else begin
                        exp_ab  = q_ab.pop_front();
                        exp_due = q_due.pop_front();
                        chk("product", DW, ab_w, exp_ab);
                        chk("latency", DW, 256'(cyc), 256'(exp_due));
                    end
                end
                prev_done = done_w;
            end
        end
    end

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            a = rnd128();
            b = rnd128();
            if (g_dut[0].done_w === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout [dw=16] cyc=%0d: got no done, expected done within %0d cycles",
                     cyc, budget);
        end
    endtask

    task automatic do_op(input logic [127:0] x, input logic [127:0] y, input int hold,
                         output logic [255:0] res);
        bit ok;
        a      = x;
        b      = y;
        enable = 1'b1;
        wait_done(40, ok);
        res = g_dut[0].ab_w;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            a = rnd128();
            b = rnd128();
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] res;
        logic [255:0] prev;
        logic [127:0] ones;
        logic [127:0] b127;
        bit           ok;

        ones = '1;
        b127 = 128'h8000_0000_0000_0000_0000_0000_0000_0000;

        rst    = 1'b0;
        enable = 1'b1;
        a      = rnd128();
        b      = rnd128();
        repeat (2) @(negedge clk);
        chk("reset_ab", 16, g_dut[0].ab_w, 256'd0);
        chk("reset_done", 16, 256'(g_dut[0].done_w), 256'd0);
        chk("reset_busy", 16, 256'(g_dut[0].busy_w), 256'd0);

        rst = 1'b1;
        do_op(128'd3, 128'd5, 20, res);
        chk("basic_3x5", 16, res, 256'd15);

        do_op(ones, ones, 0, res);
        chk("max_x_max", 16, res, {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'd1});
        do_op(128'd0, ones, 1, res);
        chk("zero_x_max", 16, res, 256'd0);
        do_op(128'd1, b127, 0, res);
        chk("one_x_2pow127", 16, res, {128'd0, b127});

        do_op(128'd194012132967336151925193938223512605765,
              128'd265378315908090481383838817922603599831, 2, res);
        chk("harness_pair", 16,  res,
            prod(128'd194012132967336151925193938223512605765,
                 128'd265378315908090481383838817922603599831));

        for (int i = 0; i < 1000; i++) begin
            do_op(rnd128(), rnd128(), $urandom_range(0, 2), res);
        end

        // Withdraw the request on the fifth run edge, then re-request at once.
        prev   = g_dut[0].ab_w;
        a      = rnd128();
        b      = rnd128();
        enable = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_no_done", 16, 256'(g_dut[0].done_w), 256'd0);
        chk("abort_retain_ab", 16, g_dut[0].ab_w, prev);
        chk("abort_not_busy", 16, 256'(g_dut[0].busy_w), 256'd0);
        do_op(128'd7, 128'd9, 0, res);
        chk("after_abort_7x9", 16, res, 256'd63);

        a      = rnd128();
        b      = rnd128();
        enable = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_run_ab", 16, g_dut[0].ab_w, 256'd0);
        chk("rst_run_busy", 16, 256'(g_dut[0].busy_w), 256'd0);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        do_op(128'd2, 128'd2, 0, res);
        chk("after_rst_run_2x2", 16, res, 256'd4);

        a      = 128'd5;
        b      = 128'd6;
        enable = 1'b1;
        wait_done(40, ok);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_done_ab", 16, g_dut[0].ab_w, 256'd0);
        chk("rst_done_done", 16, 256'(g_dut[0].done_w), 256'd0);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        do_op(128'd2, 128'd2, 0, res);
        chk("after_rst_done_2x2", 16, res, 256'd4);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
